// File: rtl/seq_div.sv
// seq_div -- sequential unsigned integer divider (restoring shift-subtract).
//
// Produces one quotient bit per clock, so a division takes WIDTH edges from
// the accepting edge to the done pulse. Division by zero skips the loop and
// completes after a single edge with quotient = all ones and
// remainder = dividend, matching RISC-V DIVU/REMU. Signed division is left to
// the caller (sign correction around this block).
//
// Ports:
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   start_i         request, sampled on a rising edge when not busy
//   dividend_i      numerator, captured with an accepted start
//   divisor_i       denominator, captured with an accepted start
//   busy_o          high while the shift-subtract loop is running
//   done_o          one-cycle pulse, results valid
//   quotient_o      registered quotient, held until the next completion
//   remainder_o     registered remainder, held likewise
//   div_by_zero_o   registered flag for the last completed operation

module seq_div #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dividendShift_q, dividendShift_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] partRem_q, partRem_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divByZero_q, divByZero_d;

  // One restoring step. The partial remainder is always below the divisor, so
  // the shifted value is below twice the divisor and WIDTH+1 bits are enough:
  // the top bit of the trial difference is set exactly when it went negative.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qBit;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuot;

  assign shifted  = {partRem_q, dividendShift_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor_q};
  assign qBit     = ~trial[WIDTH];
  assign nextRem  = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  // Quotient bits enter at the bottom as dividend bits leave at the top, so
  // after WIDTH steps this register holds the complete quotient.
  assign nextQuot = {dividendShift_q[WIDTH-2:0], qBit};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      dividendShift_q <= '0;
      divisor_q       <= '0;
      partRem_q       <= '0;
      count_q         <= '0;
      busy_q          <= 1'b0;
      quotient_q      <= '0;
      remainder_q     <= '0;
      divByZero_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      dividendShift_q <= dividendShift_d;
      divisor_q       <= divisor_d;
      partRem_q       <= partRem_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      quotient_q      <= quotient_d;
      remainder_q     <= remainder_d;
      divByZero_q     <= divByZero_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    dividendShift_d = dividendShift_q;
    divisor_d       = divisor_q;
    partRem_d       = partRem_q;
    count_d         = count_q;
    busy_d          = busy_q;
    quotient_d      = quotient_q;
    remainder_d     = remainder_q;
    divByZero_d     = divByZero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d         = RUN;
          dividendShift_d = dividend_i;
          divisor_d       = divisor_i;
          partRem_d       = '0;
          count_d         = '0;
          // A zero divisor passes through RUN for one edge without being
          // reported as busy.
          busy_d          = (divisor_i != '0);
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (divisor_q == '0) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          quotient_d  = '1;
          remainder_d = dividendShift_q;
          divByZero_d = 1'b1;
        end else begin
          dividendShift_d = nextQuot;
          partRem_d       = nextRem;
          count_d         = count_q + 1'b1;
          if (count_q == LastIter) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            quotient_d  = nextQuot;
            remainder_d = nextRem;
            divByZero_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy_o        = busy_q;
  assign done_o        = (state_q == DONE);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = divByZero_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div -- self-checking bench for seq_div (WIDTH = 64).
//
// A behavioural model tracks, per clock, whether an operation is pending and
// how many edges remain until it completes, and computes results with plain
// '/' and '%'. A compare process checks every DUT output against it on each
// falling edge; directed cases add literal expectations.

`timescale 1ns/1ps

module tb_seq_div;

  localparam int W = 64;
  localparam logic [W-1:0] AllOnes = {W{1'b1}};

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divByZero;

  int errors = 0;
  int checks = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pending operation plus edges left until completion.
  logic         mActive;
  int           mLeft;
  logic         mBusy;
  logic         mDone;
  logic [W-1:0] mA;
  logic [W-1:0] mB;
  logic [W-1:0] mQ;
  logic [W-1:0] mR;
  logic         mZ;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive = 1'b0;
      mLeft   = 0;
      mBusy   = 1'b0;
      mDone   = 1'b0;
      mA      = '0;
      mB      = '0;
      mQ      = '0;
      mR      = '0;
      mZ      = 1'b0;
    end else if (mActive) begin
      mLeft = mLeft - 1;
      if (mLeft == 0) begin
        mActive = 1'b0;
        mBusy   = 1'b0;
        mDone   = 1'b1;
        if (mB == '0) begin
          mQ = AllOnes;
          mR = mA;
          mZ = 1'b1;
        end else begin
          mQ = mA / mB;
          mR = mA % mB;
          mZ = 1'b0;
        end
      end
    end else begin
      mDone = 1'b0;
      if (start) begin
        mA      = dividend;
        mB      = divisor;
        mActive = 1'b1;
        mLeft   = (divisor == '0) ? 1 : W;
        mBusy   = (divisor != '0);
      end
    end
  end

  // Per-cycle comparison against the model, plus the division identity at
  // every completed non-zero-divisor operation.
  logic [2*W-1:0] recon;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (busy !== mBusy || done !== mDone || quotient !== mQ ||
          remainder !== mR || divByZero !== mZ) begin
        errors++;
        $display("[TB] FAIL cycle t=%0t: got busy=%b done=%b q=%h r=%h z=%b, want busy=%b done=%b q=%h r=%h z=%b",
                 $time, busy, done, quotient, remainder, divByZero,
                 mBusy, mDone, mQ, mR, mZ);
      end
      if (done && mDone && !mZ) begin
        checks++;
        recon = (2*W)'(quotient) * (2*W)'(mB) + (2*W)'(remainder);
        if (recon !== (2*W)'(mA) || !(remainder < mB)) begin
          errors++;
          $display("[TB] FAIL identity: got q=%h r=%h for a=%h b=%h",
                   quotient, remainder, mA, mB);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Caller is at a falling edge; presents a request for one rising edge and
  // returns at the falling edge just after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the falling edge of the done cycle; lat = edges since accept.
  task automatic waitDone(output int lat);
    lat = 0;
    while (!done && lat < W + 4) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: got no done after %0d edges, want done", lat);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no completion, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int doneCount;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int sel;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", W'(busy), '0);
    checkOutput("resetDone", W'(done), '0);
    checkOutput("resetQuot", quotient, '0);
    checkOutput("resetRem", remainder, '0);
    checkOutput("resetDbz", W'(divByZero), '0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic 120/29");
    applyStimulus(64'd120, 64'd29);
    checkOutput("busyAfterAccept", W'(busy), 64'd1);
    waitDone(lat);
    checkOutput("latency120_29", W'(lat), 64'd64);
    checkOutput("quot120_29", quotient, 64'd4);
    checkOutput("rem120_29", remainder, 64'd4);
    checkOutput("dbz120_29", W'(divByZero), 64'd0);

    $display("[TB] back-to-back chain");
    applyStimulus(64'd84, 64'd30);
    checkOutput("busyBackToBack", W'(busy), 64'd1);
    waitDone(lat);
    checkOutput("latency84_30", W'(lat), 64'd64);
    checkOutput("quot84_30", quotient, 64'd2);
    checkOutput("rem84_30", remainder, 64'd24);
    applyStimulus(64'd30, 64'd29);
    waitDone(lat);
    checkOutput("quot30_29", quotient, 64'd1);
    checkOutput("rem30_29", remainder, 64'd1);
    applyStimulus(64'd28, 64'd120);
    waitDone(lat);
    checkOutput("quot28_120", quotient, 64'd0);
    checkOutput("rem28_120", remainder, 64'd28);
    applyStimulus(AllOnes, 64'd1);
    waitDone(lat);
    checkOutput("quotMax_1", quotient, AllOnes);
    checkOutput("remMax_1", remainder, 64'd0);

    $display("[TB] divide by zero");
    @(negedge clk);
    @(negedge clk);
    applyStimulus(64'd120, 64'd0);
    checkOutput("busyDivZero", W'(busy), 64'd0);
    waitDone(lat);
    checkOutput("latencyDivZero", W'(lat), 64'd1);
    checkOutput("quotDivZero", quotient, AllOnes);
    checkOutput("remDivZero", remainder, 64'd120);
    checkOutput("dbzDivZero", W'(divByZero), 64'd1);

    $display("[TB] start during run is ignored");
    @(negedge clk);
    applyStimulus(64'd120, 64'd29);
    repeat (9) @(negedge clk);
    dividend = 64'd84;
    divisor  = 64'd30;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 64'd999;
    divisor  = 64'd7;
    waitDone(lat);
    checkOutput("quotIgnored", quotient, 64'd4);
    checkOutput("remIgnored", remainder, 64'd4);
    checkOutput("dbzIgnored", W'(divByZero), 64'd0);

    $display("[TB] reset mid-operation");
    @(negedge clk);
    applyStimulus(64'd200, 64'd7);
    repeat (29) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", W'(busy), '0);
    checkOutput("abortDone", W'(done), '0);
    checkOutput("abortQuot", quotient, '0);
    checkOutput("abortRem", remainder, '0);
    checkOutput("abortDbz", W'(divByZero), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("noDoneAfterAbort", W'(doneCount), '0);

    $display("[TB] random sweep");
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      a   = {$urandom(), $urandom()};
      b   = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      sel = $urandom_range(0, 15);
      case (sel)
        0: b = '0;
        1: b = 64'd1;
        2: b = a;
        3: begin
          a = W'($urandom_range(0, 1000));
          b = W'($urandom_range(1, 50));
        end
        4: a = W'($urandom_range(0, 1000));
        default: ;
      endcase
      applyStimulus(a, b);
      waitDone(lat);
    end
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
